// File: rtl/fetch_stage.sv
// fetch_stage -- instruction-fetch stage of a 5-stage MIPS pipeline.
//
// This stage owns the PC register and drives the synchronous instruction
// SRAM. It passes {ce, pc} to decode. It applies the following redirects:
//   - branch and jump targets from decode,
//   - exception/eret targets on flush.
// A hold buffer keeps id_inst stable while decode is stalled.
//
// Ports:
//   clk              rising-edge clock
//   rst              asynchronous active-low reset
//   stall            stall bus; bit 0 = PC stage, bit 1 = IF/ID register
//   br_bus           {br_e, br_addr} from decode
//   flush            exception/eret redirect, highest priority after reset
//   flush_pc         redirect target, valid while flush = 1
//   if_to_id_bus     {ce, pc} to the decode input register
//   inst_sram_en     SRAM read enable
//   inst_sram_wen    SRAM byte write enables (always 0)
//   inst_sram_addr   SRAM fetch address
//   inst_sram_wdata  SRAM write data (always 0)
//   inst_sram_rdata  SRAM read data, one cycle after the address
//   id_inst          instruction word aligned with decode's registered PC
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'hBFBF_FFFC,
    parameter int          STALL_WD = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [STALL_WD-1:0] stall,
    input  logic [32:0]         br_bus,
    input  logic                flush,
    input  logic [31:0]         flush_pc,
    output logic [32:0]         if_to_id_bus,
    output logic                inst_sram_en,
    output logic [3:0]          inst_sram_wen,
    output logic [31:0]         inst_sram_addr,
    output logic [31:0]         inst_sram_wdata,
    input  logic [31:0]         inst_sram_rdata,
    output logic [31:0]         id_inst
);

    logic [31:0] r_pc;
    logic        r_ce;
    logic        r_hold_v;
    logic [31:0] r_hold_inst;

    logic        w_br_e;
    logic [31:0] w_br_addr;
    logic [31:0] w_seq_pc;
    logic [31:0] w_next_pc;
    logic        w_unused;

    assign {w_br_e, w_br_addr} = br_bus;
    assign w_seq_pc  = r_pc + 32'd4;   // wraps modulo 2^32
    assign w_next_pc = w_br_e ? w_br_addr : w_seq_pc;

    // The upper stall bits belong to later stages.
    assign w_unused = &{1'b0, stall[STALL_WD-1:2]};

    // PC register.
    // r_ce = 0 only right after reset. That first edge is the initial load,
    // so it always happens, even if stall[0] is set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc <= RESET_PC;
            r_ce <= 1'b0;
        end else if (flush) begin
            r_pc <= flush_pc;
            r_ce <= 1'b1;
        end else if (!r_ce) begin
            r_pc <= w_seq_pc;
            r_ce <= 1'b1;
        end else if (!stall[0]) begin
            r_pc <= w_next_pc;
            r_ce <= 1'b1;
        end
    end

    // Hold buffer.
    // On the first stalled edge, the SRAM still returns the word for decode's
    // current PC. The buffer latches that word once, before the SRAM output
    // moves on to the stalled r_pc.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hold_v    <= 1'b0;
            r_hold_inst <= 32'd0;
        end else if (flush || !stall[1]) begin
            r_hold_v <= 1'b0;
        end else if (!r_hold_v) begin
            r_hold_inst <= inst_sram_rdata;
            r_hold_v    <= 1'b1;
        end
    end

    assign inst_sram_en    = r_ce;
    assign inst_sram_wen   = 4'b0000;
    assign inst_sram_addr  = r_pc;
    assign inst_sram_wdata = 32'd0;
    assign if_to_id_bus    = {r_ce, r_pc};
    assign id_inst         = r_hold_v ? r_hold_inst : inst_sram_rdata;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic [32:0] br_bus;
    logic        flush;
    logic [31:0] flush_pc;
    logic [32:0] if_to_id_bus;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata = 32'd0;
    logic [31:0] id_inst;

    int total = 0;
    int bad   = 0;

    fetch_stage dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .br_bus          (br_bus),
        .flush           (flush),
        .flush_pc        (flush_pc),
        .if_to_id_bus    (if_to_id_bus),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_wen   (inst_sram_wen),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata),
        .inst_sram_rdata (inst_sram_rdata),
        .id_inst         (id_inst)
    );

    always #5 clk = ~clk;

    // Instruction memory contents as seen by the bench.
    function automatic logic [31:0] memf(input logic [31:0] a);
        if (a == 32'hBFC0_0010) return 32'h3C01_BFD0;
        return a ^ 32'h1357_0000;
    endfunction

    // Synchronous SRAM model: data returns one cycle after the address.
    always @(posedge clk) begin
        if (inst_sram_en) inst_sram_rdata <= memf(inst_sram_addr);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; stall = '0; br_bus = '0; flush = 1'b0; flush_pc = '0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (inst_sram_en !== 1'b0) begin bad++; $display("FAIL reset_en got %h want 0", inst_sram_en); end
        total++; if (inst_sram_addr !== 32'hBFBF_FFFC) begin bad++; $display("FAIL reset_addr got %h want bfbffffc", inst_sram_addr); end
        total++; if (if_to_id_bus !== {1'b0, 32'hBFBF_FFFC}) begin bad++; $display("FAIL reset_bus got %h want 0bfbffffc", if_to_id_bus); end
        total++; if (id_inst !== inst_sram_rdata) begin bad++; $display("FAIL reset_inst got %h want %h", id_inst, inst_sram_rdata); end
        total++; if (inst_sram_wdata !== 32'd0) begin bad++; $display("FAIL reset_wdata got %h want 0", inst_sram_wdata); end
        #3 rst = 1'b1;
    endtask

    task automatic test_sequential();
        logic [31:0] exp_addr [3];
        exp_addr[0] = 32'hBFC0_0000;
        exp_addr[1] = 32'hBFC0_0004;
        exp_addr[2] = 32'hBFC0_0008;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (inst_sram_addr !== exp_addr[i]) begin bad++; $display("FAIL seq_addr%0d got %h want %h", i, inst_sram_addr, exp_addr[i]); end
            total++; if (inst_sram_en !== 1'b1) begin bad++; $display("FAIL seq_en%0d got %h want 1", i, inst_sram_en); end
            total++; if (inst_sram_wen !== 4'b0000) begin bad++; $display("FAIL seq_wen%0d got %h want 0", i, inst_sram_wen); end
            if (i > 0) begin
                total++; if (id_inst !== memf(exp_addr[i-1])) begin bad++; $display("FAIL seq_inst%0d got %h want %h", i, id_inst, memf(exp_addr[i-1])); end
            end
        end
    endtask

    task automatic test_branch();
        br_bus = {1'b1, 32'hBFC0_0100};
        step();
        total++; if (inst_sram_addr !== 32'hBFC0_0100) begin bad++; $display("FAIL br_target got %h want bfc00100", inst_sram_addr); end
        total++; if (id_inst !== memf(32'hBFC0_0008)) begin bad++; $display("FAIL br_delay_slot got %h want %h", id_inst, memf(32'hBFC0_0008)); end
        br_bus = '0;
        step();
        total++; if (inst_sram_addr !== 32'hBFC0_0104) begin bad++; $display("FAIL br_next got %h want bfc00104", inst_sram_addr); end
        total++; if (id_inst !== memf(32'hBFC0_0100)) begin bad++; $display("FAIL br_target_inst got %h want %h", id_inst, memf(32'hBFC0_0100)); end
    endtask

    task automatic test_stall();
        br_bus = {1'b1, 32'hBFC0_0010};
        step();
        br_bus = '0;
        step();
        total++; if (id_inst !== 32'h3C01_BFD0) begin bad++; $display("FAIL stall_pre got %h want 3c01bfd0", id_inst); end
        stall = 6'b000011;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (id_inst !== 32'h3C01_BFD0) begin bad++; $display("FAIL stall_hold%0d got %h want 3c01bfd0", i, id_inst); end
            total++; if (inst_sram_addr !== 32'hBFC0_0014) begin bad++; $display("FAIL stall_addr%0d got %h want bfc00014", i, inst_sram_addr); end
        end
        stall = '0;
        step();
        total++; if (id_inst !== memf(32'hBFC0_0014)) begin bad++; $display("FAIL stall_release got %h want %h", id_inst, memf(32'hBFC0_0014)); end
        total++; if (inst_sram_addr !== 32'hBFC0_0018) begin bad++; $display("FAIL stall_release_addr got %h want bfc00018", inst_sram_addr); end
    endtask

    task automatic test_flush_stall();
        stall = 6'b000111;
        step();
        total++; if (id_inst !== memf(32'hBFC0_0014)) begin bad++; $display("FAIL fl_hold got %h want %h", id_inst, memf(32'hBFC0_0014)); end
        flush = 1'b1; flush_pc = 32'hBFC0_0380; br_bus = {1'b1, 32'hBFC0_0100};
        step();
        total++; if (inst_sram_addr !== 32'hBFC0_0380) begin bad++; $display("FAIL fl_addr got %h want bfc00380", inst_sram_addr); end
        total++; if (id_inst !== memf(32'hBFC0_0018)) begin bad++; $display("FAIL fl_hold_clear got %h want %h", id_inst, memf(32'hBFC0_0018)); end
        flush = 1'b0; br_bus = '0; stall = '0;
        step();
        total++; if (inst_sram_addr !== 32'hBFC0_0384) begin bad++; $display("FAIL fl_next got %h want bfc00384", inst_sram_addr); end
    endtask

    task automatic test_branch_stall();
        stall = 6'b000001; br_bus = {1'b1, 32'hBFC0_0200};
        for (int i = 0; i < 2; i++) begin
            step();
            total++; if (inst_sram_addr !== 32'hBFC0_0384) begin bad++; $display("FAIL bs_hold%0d got %h want bfc00384", i, inst_sram_addr); end
        end
        stall = '0;
        step();
        total++; if (inst_sram_addr !== 32'hBFC0_0200) begin bad++; $display("FAIL bs_redirect got %h want bfc00200", inst_sram_addr); end
        br_bus = '0;
        step();
        total++; if (inst_sram_addr !== 32'hBFC0_0204) begin bad++; $display("FAIL bs_next got %h want bfc00204", inst_sram_addr); end
    endtask

    task automatic test_async_reset();
        stall = 6'b000011;
        step();
        total++; if (id_inst !== memf(32'hBFC0_0200)) begin bad++; $display("FAIL ar_hold got %h want %h", id_inst, memf(32'hBFC0_0200)); end
        #2 rst = 1'b0;
        #1;
        total++; if (inst_sram_en !== 1'b0) begin bad++; $display("FAIL ar_en got %h want 0", inst_sram_en); end
        total++; if (inst_sram_addr !== 32'hBFBF_FFFC) begin bad++; $display("FAIL ar_addr got %h want bfbffffc", inst_sram_addr); end
        total++; if (if_to_id_bus !== {1'b0, 32'hBFBF_FFFC}) begin bad++; $display("FAIL ar_bus got %h want 0bfbffffc", if_to_id_bus); end
        total++; if (id_inst !== memf(32'hBFC0_0204)) begin bad++; $display("FAIL ar_inst got %h want %h", id_inst, memf(32'hBFC0_0204)); end
        step();
        #2 rst = 1'b1;
        stall = 6'b000001;
        step();
        total++; if (inst_sram_addr !== 32'hBFC0_0000) begin bad++; $display("FAIL ar_initial_load got %h want bfc00000", inst_sram_addr); end
        total++; if (inst_sram_en !== 1'b1) begin bad++; $display("FAIL ar_initial_en got %h want 1", inst_sram_en); end
        step();
        total++; if (inst_sram_addr !== 32'hBFC0_0000) begin bad++; $display("FAIL ar_stall_after_load got %h want bfc00000", inst_sram_addr); end
        stall = '0;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_stall();
        test_flush_stall();
        test_branch_stall();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
